// File: rtl/dtack_pkg.sv
// rtl/dtack_pkg.sv - shared state/device-class types and default timing constants
package dtack_pkg;

    typedef enum logic [2:0] {IDLE, COUNT, HANDSHAKE, ACK, BERR} dtackState_e;

    typedef enum logic [2:0] {DEFAULT, SRAM, FLASH, CAN, DRAM} devClass_e;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_FLASH_WAIT = 4;
    localparam int DEF_SRAM_WAIT  = 1;
    localparam int DEF_TIMEOUT    = 200;

endpackage

// File: rtl/dtack_class_encoder.sv
// rtl/dtack_class_encoder.sv - priority encoder from decoder selects to device class
module dtack_class_encoder
    import dtack_pkg::*;
(
    input  logic      DramSelect_H,
    input  logic      CanBusSelect_H,
    input  logic      FlashSelect_H,
    input  logic      SramSelect_H,
    output devClass_e devClass
);

    always_comb begin
        devClass = DEFAULT;
        if (DramSelect_H)        devClass = DRAM;
        else if (CanBusSelect_H) devClass = CAN;
        else if (FlashSelect_H)  devClass = FLASH;
        else if (SramSelect_H)   devClass = SRAM;
    end

endmodule

// File: rtl/dtack_wait_state_controller.sv
// rtl/dtack_wait_state_controller.sv - registered 68k DTACK/BERR sequencer with wait states and handshake timeout
module dtack_wait_state_controller
    import dtack_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FLASH_WAIT = DEF_FLASH_WAIT,
    parameter int SRAM_WAIT  = DEF_SRAM_WAIT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic DramSelect_H,
    input  logic DramDtack_L,
    input  logic CanBusSelect_H,
    input  logic CanBusDtack_L,
    input  logic FlashSelect_H,
    input  logic SramSelect_H,
    output logic DtackOut_L,
    output logic BErr_L,
    output logic CycleActive_H
);

    localparam logic [CNT_W-1:0] FLASH_C   = CNT_W'(FLASH_WAIT);
    localparam logic [CNT_W-1:0] SRAM_C    = CNT_W'(SRAM_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    dtackState_e      state, nextState;
    devClass_e        latchedClass, nextClass, selClass;
    logic [CNT_W-1:0] waitCnt, nextCnt;
    logic             armed;
    logic             devDtack_L;

    dtack_class_encoder classEnc (
        .DramSelect_H   (DramSelect_H),
        .CanBusSelect_H (CanBusSelect_H),
        .FlashSelect_H  (FlashSelect_H),
        .SramSelect_H   (SramSelect_H),
        .devClass       (selClass)
    );

    assign devDtack_L = (latchedClass == DRAM) ? DramDtack_L : CanBusDtack_L;

    // A zero wait value skips COUNT so it acks on the same edge as DEFAULT.
    always_comb begin
        nextState = state;
        nextCnt   = waitCnt;
        nextClass = latchedClass;
        case (state)
            IDLE: begin
                if (armed && !AS_L) begin
                    nextClass = selClass;
                    case (selClass)
                        DRAM, CAN: begin
                            nextState = HANDSHAKE;
                            nextCnt   = '0;
                        end
                        FLASH: begin
                            nextState = (FLASH_C == '0) ? ACK : COUNT;
                            nextCnt   = FLASH_C;
                        end
                        SRAM: begin
                            nextState = (SRAM_C == '0) ? ACK : COUNT;
                            nextCnt   = SRAM_C;
                        end
                        default: nextState = ACK;
                    endcase
                end
            end
            COUNT: begin
                if (AS_L)                nextState = IDLE;
                else if (waitCnt == '0)  nextState = ACK;
                else                     nextCnt   = waitCnt - ONE_C;
            end
            HANDSHAKE: begin
                if (AS_L)                nextState = IDLE;
                else if (!devDtack_L)    nextState = ACK;
                else if (waitCnt + ONE_C == TIMEOUT_C) begin
                    nextState = BERR;
                    nextCnt   = TIMEOUT_C;
                end
                else                     nextCnt   = waitCnt + ONE_C;
            end
            ACK, BERR: begin
                if (AS_L) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (nextState == IDLE) nextCnt = '0;
    end

    // Outputs register the decode of the next state, so they change on the transition edge.
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state         <= IDLE;
            waitCnt       <= '0;
            latchedClass  <= DEFAULT;
            armed         <= 1'b0;
            DtackOut_L    <= 1'b1;
            BErr_L        <= 1'b1;
            CycleActive_H <= 1'b0;
        end else begin
            state         <= nextState;
            waitCnt       <= nextCnt;
            latchedClass  <= nextClass;
            armed         <= armed | AS_L;
            DtackOut_L    <= (nextState != ACK);
            BErr_L        <= (nextState != BERR);
            CycleActive_H <= (nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_dtack_wait_state_controller.sv
// tb/tb_dtack_wait_state_controller.sv - directed self-checking bench for dtack_wait_state_controller
module tb_dtack_wait_state_controller;

    logic Clk = 1'b0;
    logic Reset_H, AS_L;
    logic DramSelect_H, DramDtack_L, CanBusSelect_H, CanBusDtack_L;
    logic FlashSelect_H, SramSelect_H;
    logic DtackOut_L, BErr_L, CycleActive_H;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    dtack_wait_state_controller dut (
        .Clk            (Clk),
        .Reset_H        (Reset_H),
        .AS_L           (AS_L),
        .DramSelect_H   (DramSelect_H),
        .DramDtack_L    (DramDtack_L),
        .CanBusSelect_H (CanBusSelect_H),
        .CanBusDtack_L  (CanBusDtack_L),
        .FlashSelect_H  (FlashSelect_H),
        .SramSelect_H   (SramSelect_H),
        .DtackOut_L     (DtackOut_L),
        .BErr_L         (BErr_L),
        .CycleActive_H  (CycleActive_H)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic endCycle();
        AS_L = 1'b1;
        DramSelect_H = 1'b0; CanBusSelect_H = 1'b0; FlashSelect_H = 1'b0; SramSelect_H = 1'b0;
        DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_H = 1'b1; AS_L = 1'b0;
        DramSelect_H = 1'b0; CanBusSelect_H = 1'b0; FlashSelect_H = 1'b0; SramSelect_H = 1'b0;
        DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
        tick(); tick();
        total++; if (DtackOut_L !== 1'b1) $display("FAIL reset_dtack got %b want 1", DtackOut_L); else passed++;
        total++; if (BErr_L !== 1'b1) $display("FAIL reset_berr got %b want 1", BErr_L); else passed++;
        total++; if (CycleActive_H !== 1'b0) $display("FAIL reset_active got %b want 0", CycleActive_H); else passed++;
        Reset_H = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            total++;
            if (DtackOut_L !== 1'b1 || CycleActive_H !== 1'b0)
                $display("FAIL reset_rearm edge %0d got dtack=%b active=%b want 1/0", e, DtackOut_L, CycleActive_H);
            else passed++;
        end
        AS_L = 1'b1; tick();
        AS_L = 1'b0; tick();
        total++; if (DtackOut_L !== 1'b0) $display("FAIL reset_first_cycle got %b want 0", DtackOut_L); else passed++;
        endCycle();
    endtask

    task automatic test_default();
        AS_L = 1'b0;
        for (int e = 0; e <= 5; e++) begin
            if (e == 5) AS_L = 1'b1;
            tick();
            total++;
            if (DtackOut_L !== (e == 5) || CycleActive_H !== (e != 5))
                $display("FAIL default edge %0d got dtack=%b active=%b want %b/%b",
                         e, DtackOut_L, CycleActive_H, (e == 5), (e != 5));
            else passed++;
        end
    endtask

    task automatic test_wait_states(input bit isFlash, input int ackEdge);
        FlashSelect_H = isFlash; SramSelect_H = !isFlash; AS_L = 1'b0;
        for (int e = 0; e <= ackEdge + 1; e++) begin
            tick();
            total++;
            if (DtackOut_L !== (e < ackEdge) || BErr_L !== 1'b1)
                $display("FAIL wait_%s edge %0d got dtack=%b berr=%b want %b/1",
                         isFlash ? "flash" : "sram", e, DtackOut_L, BErr_L, (e < ackEdge));
            else passed++;
        end
        endCycle();
    endtask

    task automatic test_priority();
        DramSelect_H = 1'b1; FlashSelect_H = 1'b1; DramDtack_L = 1'b1; AS_L = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            tick();
            total++;
            if (DtackOut_L !== (e < 8) || BErr_L !== 1'b1)
                $display("FAIL priority_dram edge %0d got dtack=%b berr=%b want %b/1", e, DtackOut_L, BErr_L, (e < 8));
            else passed++;
            if (e == 7) DramDtack_L = 1'b0;
        end
        endCycle();
    endtask

    task automatic test_timeout();
        CanBusSelect_H = 1'b1; CanBusDtack_L = 1'b1; AS_L = 1'b0;
        for (int e = 0; e <= 205; e++) begin
            tick();
            total++;
            if (BErr_L !== (e < 200) || DtackOut_L !== 1'b1)
                $display("FAIL can_timeout edge %0d got berr=%b dtack=%b want %b/1", e, BErr_L, DtackOut_L, (e < 200));
            else passed++;
        end
        endCycle();
        total++;
        if (BErr_L !== 1'b1 || CycleActive_H !== 1'b0)
            $display("FAIL timeout_release got berr=%b active=%b want 1/0", BErr_L, CycleActive_H);
        else passed++;
    endtask

    task automatic test_timeout_race();
        CanBusSelect_H = 1'b1; CanBusDtack_L = 1'b1; AS_L = 1'b0;
        for (int e = 0; e <= 202; e++) begin
            tick();
            if (e >= 198) begin
                total++;
                if (DtackOut_L !== (e < 200) || BErr_L !== 1'b1)
                    $display("FAIL timeout_race edge %0d got dtack=%b berr=%b want %b/1", e, DtackOut_L, BErr_L, (e < 200));
                else passed++;
            end
            if (e == 199) CanBusDtack_L = 1'b0;
        end
        endCycle();
    endtask

    task automatic test_abort();
        FlashSelect_H = 1'b1; AS_L = 1'b0;
        tick(); tick();
        AS_L = 1'b1;
        for (int e = 2; e <= 6; e++) begin
            tick();
            total++;
            if (DtackOut_L !== 1'b1 || BErr_L !== 1'b1 || CycleActive_H !== 1'b0)
                $display("FAIL abort edge %0d got dtack=%b berr=%b active=%b want 1/1/0", e, DtackOut_L, BErr_L, CycleActive_H);
            else passed++;
        end
        FlashSelect_H = 1'b0; AS_L = 1'b0;
        tick();
        total++; if (DtackOut_L !== 1'b0) $display("FAIL abort_next_default got %b want 0", DtackOut_L); else passed++;
        endCycle();
    endtask

    task automatic test_reset_in_count();
        FlashSelect_H = 1'b1; AS_L = 1'b0;
        tick(); tick();
        total++; if (CycleActive_H !== 1'b1) $display("FAIL count_active got %b want 1", CycleActive_H); else passed++;
        Reset_H = 1'b1;
        tick();
        total++;
        if (DtackOut_L !== 1'b1 || BErr_L !== 1'b1 || CycleActive_H !== 1'b0)
            $display("FAIL reset_in_count got dtack=%b berr=%b active=%b want 1/1/0", DtackOut_L, BErr_L, CycleActive_H);
        else passed++;
        Reset_H = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            total++;
            if (DtackOut_L !== 1'b1 || CycleActive_H !== 1'b0)
                $display("FAIL reset_in_count_hold edge %0d got dtack=%b active=%b want 1/0", e, DtackOut_L, CycleActive_H);
            else passed++;
        end
        endCycle();
    endtask

    initial begin
        test_reset();
        test_default();
        test_wait_states(1'b1, 5);
        test_wait_states(1'b0, 2);
        test_priority();
        test_timeout();
        test_timeout_race();
        test_abort();
        test_reset_in_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dtack_wait_state_controller.md
Name: dtack_wait_state_controller

Overview:
- Registered, clocked replacement for the combinational 68k DTACK generator. It sequences every CPU bus cycle from AS_L assertion to negation.
- Inserts a programmable number of wait states for fixed-latency slow devices (Flash, SRAM), forwards handshake DTACKs from the DRAM and CAN bus controllers, and returns DTACK immediately for all other devices.
- Raises a bus error (BErr_L) if a handshake device never answers.
- Sits between the address decoder, the device controllers and the CPU DTACK/BERR pins.

Parameters:
- CNT_W, 8, width of the wait/timeout counter.
- FLASH_WAIT, 4, wait states (clocks) before DTACK for Flash; legal range 0..2^CNT_W-1.
- SRAM_WAIT, 1, wait states before DTACK for SRAM; legal range 0..2^CNT_W-1.
- TIMEOUT, 200, clocks allowed for DramDtack_L/CanBusDtack_L before bus error; must be >= 1 and <= 2^CNT_W-1.

Ports:
- Clk  in  1  system clock.
- Reset_H  in  1  synchronous, active-high reset.
- AS_L  in  1  CPU address strobe, synchronous to Clk.
- DramSelect_H  in  1  address decoder: DRAM selected.
- DramDtack_L  in  1  DRAM controller DTACK.
- CanBusSelect_H  in  1  address decoder: CAN bus selected.
- CanBusDtack_L  in  1  CAN controller DTACK.
- FlashSelect_H  in  1  address decoder: Flash selected.
- SramSelect_H  in  1  address decoder: SRAM selected.
- DtackOut_L  out  1  DTACK to CPU, registered.
- BErr_L  out  1  bus error to CPU, registered.
- CycleActive_H  out  1  high while a bus cycle is being sequenced (debug/LED).

Behaviour:
- Clock, reset and outputs
  - One clock (Clk). Reset is synchronous and active-high (Reset_H).
  - Reset forces state IDLE, counter 0, DtackOut_L=1, BErr_L=1, CycleActive_H=0.
  - Reset mid-cycle aborts the cycle with no DTACK; the controller re-arms only after AS_L has been seen high.
  - All outputs are registered; no combinational path exists from inputs to outputs.
- IDLE: DtackOut_L=1, BErr_L=1. On the first edge with AS_L=0, latch the device class from the selects using fixed priority DRAM > CAN > FLASH > SRAM > DEFAULT, then go to:
  - DEFAULT: ACK, with DtackOut_L=0 in the same edge. One-clock latency from AS_L low.
  - FLASH or SRAM: COUNT, loading the counter with FLASH_WAIT or SRAM_WAIT.
  - DRAM or CAN: HANDSHAKE, with counter cleared.
- Selects are sampled only on the IDLE->active edge and ignored for the rest of the cycle.
- COUNT: the counter decrements each clock. When it reaches 0, go to ACK and drive DtackOut_L=0. A wait value of 0 behaves exactly like DEFAULT, i.e. DTACK on the first edge. A wait value of N gives DTACK low N+1 clocks after AS_L was sampled low.
- HANDSHAKE:
  - Each clock, sample the latched class's device DTACK. If it is low, go to ACK and drive DtackOut_L=0 on that edge, adding one clock of latency.
  - Otherwise increment the counter. When the counter equals TIMEOUT with no DTACK, go to BERR and drive BErr_L=0, DtackOut_L=1.
  - If the device DTACK goes low on the same edge the counter would reach TIMEOUT, DTACK wins (ACK, no bus error).
- ACK and BERR: hold their outputs until AS_L is sampled high. On that edge go to IDLE with DtackOut_L=1, BErr_L=1.
- Aborted cycle: AS_L sampled high in COUNT or HANDSHAKE returns to IDLE with no DTACK and no BERR.
- Back-to-back cycles: AS_L must be seen high for at least one edge, which forces IDLE. A new cycle starts on the next low sample.
- CycleActive_H is high in every state except IDLE.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps: it saturates at the TIMEOUT compare and at 0 in COUNT.

Decomposition:
- Shared package dtack_pkg holds:
  - state enum: IDLE, COUNT, HANDSHAKE, ACK, BERR.
  - device-class enum: DEFAULT, SRAM, FLASH, CAN, DRAM.
  - default wait/timeout constants.
- One natural sub-module, dtack_class_encoder: the combinational priority encoder from the select lines to the device class. The FSM and counter stay in the top module.

Test Plan:
- Reset_H=1 for 2 clocks with AS_L=0 -> DtackOut_L=1, BErr_L=1, CycleActive_H=0. After reset, no DTACK until AS_L has gone 1 then 0.
- No selects, AS_L low at edge 0 -> DtackOut_L=0 after edge 0 and held. AS_L high at edge 5 -> DtackOut_L=1 after edge 5.
- FlashSelect_H=1, FLASH_WAIT=4, AS_L low at edge 0 -> DtackOut_L low after edge 5 (5 clocks). Repeat with SramSelect_H=1, SRAM_WAIT=1 -> low after edge 2.
- DramSelect_H=1 and FlashSelect_H=1 together, DramDtack_L low at edge 7 -> DtackOut_L low after edge 8 (DRAM priority, no Flash timing), BErr_L stays 1.
- CanBusSelect_H=1, CanBusDtack_L held 1, TIMEOUT=200 -> BErr_L=0 200 clocks after entry and held until AS_L high; DtackOut_L stays 1. Edge case: CanBusDtack_L goes low on the timeout edge -> DtackOut_L=0, BErr_L=1.
- Abort: Flash cycle with AS_L returned high at edge 2 -> no DTACK, back to IDLE. A following default cycle acks in 1 clock. Reset asserted in COUNT -> all outputs idle next edge.
